// File: rtl/mental_math_round_ctrl.sv
// -----------------------------------------------------------------------------
// mental_math_round_ctrl
//   Round controller for the binary mental-math game. Each round an 8-bit LFSR
//   supplies two 4-bit operands, a BCD countdown runs on a 1 s game tick, and
//   the player's switch answer is checked against (A+B) mod 16. A BCD score and
//   every digit nibble for the downstream 7-segment decoders are held in
//   registers.
//
//   Ports
//     clk, rst_n              system clock, asynchronous active-low reset
//     start, submit           one-cycle pulses (debounced upstream)
//     sw_answer[3:0]          player's binary answer
//     dig_op_a/dig_op_b       operand nibbles
//     dig_time_tens/_ones     round timer, BCD
//     dig_score_tens/_ones    score, BCD
//     correct_led/wrong_led   result indication, held for RESULT_TICKS ticks
//     game_over               high once all ROUNDS have been played
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   LOAD   | one cycle: latch operands, step LFSR, reload timer
//   PLAY   | timer counting down, waiting for submit or timeout
//   RESULT | LEDs show outcome for RESULT_TICKS ticks
//   DONE   | game finished, score held, start begins a new game
// -----------------------------------------------------------------------------
module mental_math_round_ctrl #(
    parameter int          TICK_DIV     = 50_000_000,
    parameter int          TIME_LIMIT   = 10,
    parameter int          ROUNDS       = 10,
    parameter int          RESULT_TICKS = 2,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       submit,
    input  logic [3:0] sw_answer,
    output logic [3:0] dig_op_a,
    output logic [3:0] dig_op_b,
    output logic [3:0] dig_time_tens,
    output logic [3:0] dig_time_ones,
    output logic [3:0] dig_score_tens,
    output logic [3:0] dig_score_ones,
    output logic       correct_led,
    output logic       wrong_led,
    output logic       game_over
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_RESULT = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int              DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam int              RT_W     = $clog2(RESULT_TICKS + 1);
    localparam logic [RT_W-1:0]  RT_LOAD  = RT_W'(RESULT_TICKS - 1);
    localparam logic [3:0]      TL_TENS  = 4'(TIME_LIMIT / 10);
    localparam logic [3:0]      TL_ONES  = 4'(TIME_LIMIT % 10);
    localparam logic [3:0]      ROUNDS_C = 4'(ROUNDS);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [7:0]       r_lfsr;
    logic [DIV_W-1:0] r_div;
    logic [RT_W-1:0]  r_rt;
    logic [3:0]       r_round_cnt;
    logic [3:0]       r_op_a, r_op_b;
    logic [3:0]       r_time_tens, r_time_ones;
    logic [3:0]       r_score_tens, r_score_ones;
    logic             r_correct, r_wrong, r_game_over;

    logic             w_tick;
    logic [3:0]       w_sum;
    logic             w_answer_ok;
    logic             w_timer_one;
    logic             w_lfsr_fb;

    assign w_tick      = ((r_state == S_PLAY) || (r_state == S_RESULT)) && (r_div == DIV_LAST);
    assign w_sum       = r_op_a + r_op_b;
    assign w_answer_ok = (sw_answer == w_sum);
    assign w_timer_one = (r_time_tens == 4'd0) && (r_time_ones == 4'd1);
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_LOAD;
            S_LOAD:   w_next_state = S_PLAY;
            S_PLAY: begin
                // submit wins over a simultaneous final tick
                if (submit)                     w_next_state = S_RESULT;
                else if (w_tick && w_timer_one) w_next_state = S_RESULT;
            end
            S_RESULT: begin
                if (w_tick && (r_rt == '0))
                    w_next_state = (r_round_cnt == ROUNDS_C) ? S_DONE : S_LOAD;
            end
            S_DONE:   if (start) w_next_state = S_LOAD;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_SEED;
            r_div        <= '0;
            r_rt         <= '0;
            r_round_cnt  <= 4'd0;
            r_op_a       <= 4'd0;
            r_op_b       <= 4'd0;
            r_time_tens  <= TL_TENS;
            r_time_ones  <= TL_ONES;
            r_score_tens <= 4'd0;
            r_score_ones <= 4'd0;
            r_correct    <= 1'b0;
            r_wrong      <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Divider runs only while staying in PLAY/RESULT; any transition
            // (into RESULT, into LOAD, out to DONE) leaves it at zero.
            if (((r_state == S_PLAY) || (r_state == S_RESULT)) && (w_next_state == r_state))
                r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            else
                r_div <= '0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_score_tens <= 4'd0;
                        r_score_ones <= 4'd0;
                        r_round_cnt  <= 4'd0;
                    end
                end
                S_LOAD: begin
                    r_op_a      <= r_lfsr[7:4];
                    r_op_b      <= r_lfsr[3:0];
                    r_lfsr      <= {r_lfsr[6:0], w_lfsr_fb};
                    r_time_tens <= TL_TENS;
                    r_time_ones <= TL_ONES;
                end
                S_PLAY: begin
                    if (submit) begin
                        r_round_cnt <= r_round_cnt + 4'd1;
                        r_rt        <= RT_LOAD;
                        if (w_answer_ok) begin
                            r_correct <= 1'b1;
                            if (!((r_score_tens == 4'd9) && (r_score_ones == 4'd9))) begin
                                if (r_score_ones == 4'd9) begin
                                    r_score_ones <= 4'd0;
                                    r_score_tens <= r_score_tens + 4'd1;
                                end else begin
                                    r_score_ones <= r_score_ones + 4'd1;
                                end
                            end
                        end else begin
                            r_wrong <= 1'b1;
                        end
                    end else if (w_tick) begin
                        if (w_timer_one) begin
                            r_time_ones <= 4'd0;
                            r_wrong     <= 1'b1;
                            r_round_cnt <= r_round_cnt + 4'd1;
                            r_rt        <= RT_LOAD;
                        end else if (r_time_ones == 4'd0) begin
                            r_time_ones <= 4'd9;
                            r_time_tens <= r_time_tens - 4'd1;
                        end else begin
                            r_time_ones <= r_time_ones - 4'd1;
                        end
                    end
                end
                S_RESULT: begin
                    if (w_tick) begin
                        if (r_rt == '0) begin
                            r_correct <= 1'b0;
                            r_wrong   <= 1'b0;
                            if (r_round_cnt == ROUNDS_C) r_game_over <= 1'b1;
                        end else begin
                            r_rt <= r_rt - RT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_score_tens <= 4'd0;
                        r_score_ones <= 4'd0;
                        r_round_cnt  <= 4'd0;
                        r_game_over  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dig_op_a       = r_op_a;
    assign dig_op_b       = r_op_b;
    assign dig_time_tens  = r_time_tens;
    assign dig_time_ones  = r_time_ones;
    assign dig_score_tens = r_score_tens;
    assign dig_score_ones = r_score_ones;
    assign correct_led    = r_correct;
    assign wrong_led      = r_wrong;
    assign game_over      = r_game_over;

endmodule

// File: tb/tb_mental_math_round_ctrl.sv
module tb_mental_math_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [3:0] sw_answer = 4'd0;
    logic [3:0] dig_op_a, dig_op_b, dig_time_tens, dig_time_ones;
    logic [3:0] dig_score_tens, dig_score_ones;
    logic       correct_led, wrong_led, game_over;

    int n_checks = 0;
    int n_pass   = 0;

    mental_math_round_ctrl #(
        .TICK_DIV(4), .TIME_LIMIT(5), .ROUNDS(2), .RESULT_TICKS(2), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .submit(submit), .sw_answer(sw_answer),
        .dig_op_a(dig_op_a), .dig_op_b(dig_op_b),
        .dig_time_tens(dig_time_tens), .dig_time_ones(dig_time_ones),
        .dig_score_tens(dig_score_tens), .dig_score_ones(dig_score_ones),
        .correct_led(correct_led), .wrong_led(wrong_led), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       sb;
        logic [3:0] sw;
        int         n_wait;
        logic       chk_time;
        logic [3:0] a, b, tt, to, sct, sco;
        logic       c, w, g;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic st_i, input logic sb_i, input logic [3:0] sw_i,
                                input int nw, input logic ct,
                                input logic [3:0] a_i, input logic [3:0] b_i,
                                input logic [3:0] tt_i, input logic [3:0] to_i,
                                input logic [3:0] sct_i, input logic [3:0] sco_i,
                                input logic c_i, input logic w_i, input logic g_i);
        vec_t v;
        v.st = st_i; v.sb = sb_i; v.sw = sw_i; v.n_wait = nw; v.chk_time = ct;
        v.a = a_i; v.b = b_i; v.tt = tt_i; v.to = to_i; v.sct = sct_i; v.sco = sco_i;
        v.c = c_i; v.w = w_i; v.g = g_i;
        return v;
    endfunction

    function automatic logic [26:0] pack_out(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] tt, input logic [3:0] to,
                                             input logic [3:0] sct, input logic [3:0] sco,
                                             input logic c, input logic w, input logic g);
        return {a, b, tt, to, sct, sco, c, w, g};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] dut_out();
        return pack_out(dig_op_a, dig_op_b, dig_time_tens, dig_time_ones,
                        dig_score_tens, dig_score_ones, correct_led, wrong_led, game_over);
    endfunction

    initial begin
        logic [26:0] got, exp, mask;

        //            st sb sw  wait ct  a     b     tt    to    sct   sco   c w g
        vecs[0]  = mk(0, 0, 4'h0, 0, 1, 4'h0, 4'h0, 4'd0, 4'd5, 4'd0, 4'd0, 0,0,0); // reset state
        vecs[1]  = mk(1, 0, 4'h0, 1, 1, 4'hA, 4'h5, 4'd0, 4'd5, 4'd0, 4'd0, 0,0,0); // round 1 ops
        vecs[2]  = mk(0, 1, 4'hF, 0, 1, 4'hA, 4'h5, 4'd0, 4'd5, 4'd0, 4'd1, 1,0,0); // correct
        vecs[3]  = mk(0, 0, 4'h0, 6, 1, 4'hA, 4'h5, 4'd0, 4'd5, 4'd0, 4'd1, 1,0,0); // LED still held
        vecs[4]  = mk(0, 0, 4'h0, 0, 1, 4'hA, 4'h5, 4'd0, 4'd5, 4'd0, 4'd1, 0,0,0); // LED clears at 8
        vecs[5]  = mk(0, 0, 4'h0, 0, 1, 4'h4, 4'hA, 4'd0, 4'd5, 4'd0, 4'd1, 0,0,0); // round 2 ops
        vecs[6]  = mk(0, 1, 4'h0, 0, 1, 4'h4, 4'hA, 4'd0, 4'd5, 4'd0, 4'd1, 0,1,0); // wrong answer
        vecs[7]  = mk(0, 0, 4'h0, 7, 1, 4'h4, 4'hA, 4'd0, 4'd5, 4'd0, 4'd1, 0,0,1); // game over
        vecs[8]  = mk(0, 0, 4'h0, 3, 1, 4'h4, 4'hA, 4'd0, 4'd5, 4'd0, 4'd1, 0,0,1); // DONE holds
        vecs[9]  = mk(1, 0, 4'h0, 1, 1, 4'h9, 4'h5, 4'd0, 4'd5, 4'd0, 4'd0, 0,0,0); // restart, lfsr continues
        vecs[10] = mk(0, 0, 4'h0, 3, 1, 4'h9, 4'h5, 4'd0, 4'd4, 4'd0, 4'd0, 0,0,0); // tick 1
        vecs[11] = mk(1, 0, 4'h0, 3, 1, 4'h9, 4'h5, 4'd0, 4'd3, 4'd0, 4'd0, 0,0,0); // tick 2, start ignored
        vecs[12] = mk(0, 0, 4'h0, 3, 1, 4'h9, 4'h5, 4'd0, 4'd2, 4'd0, 4'd0, 0,0,0); // tick 3
        vecs[13] = mk(0, 0, 4'h0, 3, 1, 4'h9, 4'h5, 4'd0, 4'd1, 4'd0, 4'd0, 0,0,0); // tick 4
        vecs[14] = mk(0, 0, 4'h0, 3, 1, 4'h9, 4'h5, 4'd0, 4'd0, 4'd0, 4'd0, 0,1,0); // timeout
        vecs[15] = mk(0, 1, 4'h0, 7, 1, 4'h9, 4'h5, 4'd0, 4'd0, 4'd0, 4'd0, 0,0,0); // submit ignored in RESULT
        vecs[16] = mk(0, 0, 4'h0, 0, 1, 4'h2, 4'hA, 4'd0, 4'd5, 4'd0, 4'd0, 0,0,0); // next round ops
        vecs[17] = mk(0, 0, 4'h0, 15, 1, 4'h2, 4'hA, 4'd0, 4'd1, 4'd0, 4'd0, 0,0,0); // after 4 ticks
        vecs[18] = mk(0, 0, 4'h0, 2, 1, 4'h2, 4'hA, 4'd0, 4'd1, 4'd0, 4'd0, 0,0,0); // just before 5th tick
        vecs[19] = mk(0, 1, 4'hC, 0, 0, 4'h2, 4'hA, 4'd0, 4'd0, 4'd0, 4'd1, 1,0,0); // submit on final tick
        vecs[20] = mk(0, 0, 4'h0, 7, 0, 4'h2, 4'hA, 4'd0, 4'd0, 4'd0, 4'd1, 0,0,1); // second game over

        repeat (3) cyc();
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            start = vecs[i].st;
            submit = vecs[i].sb;
            sw_answer = vecs[i].sw;
            cyc();
            start = 1'b0;
            submit = 1'b0;
            repeat (vecs[i].n_wait) cyc();
            mask = vecs[i].chk_time ? '1 : ~{8'h00, 8'hFF, 11'h000};
            exp = pack_out(vecs[i].a, vecs[i].b, vecs[i].tt, vecs[i].to,
                           vecs[i].sct, vecs[i].sco, vecs[i].c, vecs[i].w, vecs[i].g);
            got = dut_out();
            check($sformatf("vec%0d", i), 32'(got & mask), 32'(exp & mask));
        end

        // Third game mid-PLAY, then asynchronous reset between clock edges.
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        check("g3_ops", 32'({dig_op_a, dig_op_b}), 32'h54);
        repeat (4) cyc();
        check("g3_tick", 32'({dig_time_tens, dig_time_ones}), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'(dut_out()), 32'(pack_out(4'h0, 4'h0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0)));
        cyc();
        rst_n = 1'b1;
        cyc();
        check("idle_after_rst", 32'(dut_out()), 32'(pack_out(4'h0, 4'h0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0)));
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        check("reseed_ops", 32'({dig_op_a, dig_op_b}), 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
